commit_trace: RTL and testbench

COMMIT_TRACE -- requirements
Module: commit_trace

---
 rtl/commit_trace_pkg.sv | 38 +++
 rtl/commit_trace_if.sv | 25 ++
 rtl/commit_trace_fifo.sv | 90 +++++++++
 rtl/commit_trace.sv | 138 +++++++++++++
 tb/tb_commit_trace.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/commit_trace_pkg.sv
// commit_trace_pkg: shared types for the commit trace block.
// Holds the record type enum, the trace record struct, the run/halted
// state enum and the default FIFO depth. Optional timestamping is selected
// with the COMMIT_TRACE_TIMESTAMP_EN macro in the files that use it.
package commit_trace_pkg;

   localparam int DEFAULT_DEPTH = 8;

   typedef enum logic [1:0] {
      TR_REG   = 2'd0,
      TR_LOAD  = 2'd1,
      TR_STORE = 2'd2,
      TR_HALT  = 2'd3
   } trace_type_e;

   typedef enum logic {
      ST_RUN    = 1'b0,
      ST_HALTED = 1'b1
   } run_state_e;

   typedef struct packed {
      trace_type_e rec_type;
      logic [15:0] addr;
      logic [15:0] data;
      logic [31:0] cycle;
   } trace_rec_t;

   function automatic trace_rec_t make_rec(input trace_type_e t, input logic [15:0] a,
                                           input logic [15:0] d, input logic [31:0] c);
      trace_rec_t r;
      r.rec_type = t;
      r.addr     = a;
      r.data     = d;
      r.cycle    = c;
      return r;
   endfunction

endpackage

// File: rtl/commit_trace_if.sv
// commit_trace_if: trace record stream from commit_trace to its consumer.
// Handshake: the producer holds traceValid and the record fields stable
// until a rising edge where traceValid and traceReady are both high; that
// edge transfers (pops) the record. traceReady may change freely and does
// not depend on traceValid.
interface commit_trace_if;
   import commit_trace_pkg::*;

   logic        traceValid;
   logic        traceReady;
   trace_type_e traceType;
   logic [15:0] traceAddr;
   logic [15:0] traceData;
   logic [31:0] traceCycle;

   modport master (
      output traceValid, traceType, traceAddr, traceData, traceCycle,
      input  traceReady
   );

   modport slave (
      input  traceValid, traceType, traceAddr, traceData, traceCycle,
      output traceReady
   );
endinterface

// File: rtl/commit_trace_fifo.sv
// trace_fifo: record FIFO accepting 0-3 writes and 1 read per edge.
// The head record is held in registers so the consumer sees flop outputs;
// a record written into an empty FIFO appears at the head after that edge.
// Cycle stamps are stored only when COMMIT_TRACE_TIMESTAMP_EN is defined.
module trace_fifo
   import commit_trace_pkg::*;
#(
   parameter  int DEPTH = DEFAULT_DEPTH,
   localparam int PW    = $clog2(DEPTH),
   localparam int CW    = PW + 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [1:0]       wr_num,
   input  trace_rec_t [2:0] wr_rec,
   input  logic             pop,
   output logic             head_valid,
   output trace_rec_t       head_rec,
   output logic [CW-1:0]    count
);

   logic [33:0]   body_mem [DEPTH];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   logic [31:0]   cyc_mem [DEPTH];
`else
   logic          unused_cycles;
   assign unused_cycles = ^{wr_rec[0].cycle, wr_rec[1].cycle, wr_rec[2].cycle};
`endif
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] next_rd;
   logic [CW-1:0] remain;
   logic [CW-1:0] next_count;
   logic          pop_ok;
   trace_rec_t    next_head;

   // Next occupancy, next read pointer and the record that will sit at the head.
   always_comb begin
      pop_ok     = pop && (count != '0);
      remain     = count - CW'(pop_ok);
      next_count = remain + CW'(wr_num);
      next_rd    = rd_ptr + PW'(pop_ok);
      next_head  = '0;
      if (remain != '0) begin
         next_head.rec_type = trace_type_e'(body_mem[next_rd][33:32]);
         next_head.addr     = body_mem[next_rd][31:16];
         next_head.data     = body_mem[next_rd][15:0];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
         next_head.cycle    = cyc_mem[next_rd];
`endif
      end else if (wr_num != 2'd0) begin
         next_head.rec_type = wr_rec[0].rec_type;
         next_head.addr     = wr_rec[0].addr;
         next_head.data     = wr_rec[0].data;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
         next_head.cycle    = wr_rec[0].cycle;
`endif
      end
   end

   // Storage writes into consecutive free slots starting at the write pointer.
   always_ff @(posedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (2'(i) < wr_num) begin
            body_mem[wr_ptr + PW'(i)] <= {wr_rec[i].rec_type, wr_rec[i].addr, wr_rec[i].data};
`ifdef COMMIT_TRACE_TIMESTAMP_EN
            cyc_mem[wr_ptr + PW'(i)]  <= wr_rec[i].cycle;
`endif
         end
      end
   end

   // Pointers, occupancy and registered head outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rd_ptr     <= '0;
         wr_ptr     <= '0;
         count      <= '0;
         head_valid <= 1'b0;
         head_rec   <= '0;
      end else begin
         rd_ptr     <= next_rd;
         wr_ptr     <= wr_ptr + PW'(wr_num);
         count      <= next_count;
         head_valid <= (next_count != '0);
         head_rec   <= next_head;
      end
   end

endmodule

// File: rtl/commit_trace.sv
// commit_trace: turns per-cycle commit events into a stream of trace
// records (REG, LOAD/STORE, HALT), tracks committed instructions, flags
// dropped events and stops capturing once a HALT record is queued.
// Define COMMIT_TRACE_TIMESTAMP_EN to stamp each record with a free-running
// cycle counter; otherwise traceCycle is constant 0.
module commit_trace
   import commit_trace_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  regWrite,
   input  logic [2:0]            writeReg,
   input  logic [15:0]           writeData,
   input  logic                  memRead,
   input  logic                  memWrite,
   input  logic [15:0]           memAddr,
   input  logic [15:0]           memDataIn,
   input  logic [15:0]           memDataOut,
   input  logic                  halt,
   commit_trace_if.master        trace,
   output logic [31:0]           instCount,
   output logic                  overflow,
   output logic                  halted,
   output logic                  drained
);

   localparam int CW = $clog2(DEPTH) + 1;

   run_state_e       state;
   run_state_e       state_next;
   trace_rec_t [2:0] rec;
   logic [1:0]       n_form;
   logic [1:0]       wr_num;
   logic [CW-1:0]    count;
   logic [CW-1:0]    free;
   logic             drop;
   logic             counts_inst;
   logic             pop;
   logic             head_valid;
   trace_rec_t       head_rec;
   logic [31:0]      stamp;

`ifdef COMMIT_TRACE_TIMESTAMP_EN
   logic [31:0] cyc_cnt;

   // Free-running wrapping cycle counter, zero on the first edge after reset.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) cyc_cnt <= '0;
      else      cyc_cnt <= cyc_cnt + 32'd1;
   end

   assign stamp = cyc_cnt;
`else
   assign stamp = '0;
`endif

   // Record formation, space check (free counted before this edge's pop) and halt transition.
   always_comb begin
      rec         = '0;
      n_form      = 2'd0;
      wr_num      = 2'd0;
      drop        = 1'b0;
      counts_inst = 1'b0;
      state_next  = state;
      free        = CW'(DEPTH) - count;
      if (state == ST_RUN) begin
         counts_inst = halt | regWrite | memWrite;
         if (regWrite) begin
            rec[n_form] = make_rec(TR_REG, {13'd0, writeReg}, writeData, stamp);
            n_form      = n_form + 2'd1;
         end
         // A store wins when both memory strobes are high.
         if (memWrite) begin
            rec[n_form] = make_rec(TR_STORE, memAddr, memDataIn, stamp);
            n_form      = n_form + 2'd1;
         end else if (memRead) begin
            rec[n_form] = make_rec(TR_LOAD, memAddr, memDataOut, stamp);
            n_form      = n_form + 2'd1;
         end
         if (halt) begin
            rec[n_form] = make_rec(TR_HALT, 16'd0, 16'd0, stamp);
            n_form      = n_form + 2'd1;
         end
         if (CW'(n_form) <= free) begin
            wr_num = n_form;
         end else begin
            // Not enough room: drop everything, but keep the HALT if one slot is free.
            drop = 1'b1;
            if (halt && (free != '0)) begin
               rec[0] = make_rec(TR_HALT, 16'd0, 16'd0, stamp);
               wr_num = 2'd1;
            end
         end
         if (halt && (free != '0)) state_next = ST_HALTED;
      end
   end

   // Run/halted state register; halted is the exposed state bit.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_RUN;
      else      state <= state_next;
   end

   // Committed-instruction counter (saturating) and sticky overflow flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         instCount <= '0;
         overflow  <= 1'b0;
      end else begin
         overflow <= overflow | drop;
         if (counts_inst && (instCount != 32'hFFFF_FFFF)) instCount <= instCount + 32'd1;
      end
   end

   assign pop     = head_valid & trace.traceReady;
   assign halted  = (state == ST_HALTED);
   assign drained = halted && (count == '0);

   trace_fifo #(.DEPTH(DEPTH)) u_fifo (
      .clk        (clk),
      .rst        (rst),
      .wr_num     (wr_num),
      .wr_rec     (rec),
      .pop        (pop),
      .head_valid (head_valid),
      .head_rec   (head_rec),
      .count      (count)
   );

   assign trace.traceValid = head_valid;
   assign trace.traceType  = head_rec.rec_type;
   assign trace.traceAddr  = head_rec.addr;
   assign trace.traceData  = head_rec.data;
   assign trace.traceCycle = head_rec.cycle;

endmodule

// File: tb/tb_commit_trace.sv
// tb_commit_trace: randomized and directed stimulus for commit_trace with a
// queue-based reference model and a monitor that checks every popped record.
`timescale 1ns/1ps
module tb_commit_trace;
   import commit_trace_pkg::*;

   localparam int DEPTH = 8;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   localparam bit TS = 1'b1;
`else
   localparam bit TS = 1'b0;
`endif

   // ---------------- clock / reset ----------------
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   always #5 clk = ~clk;

   logic        regWrite   = 1'b0;
   logic [2:0]  writeReg   = '0;
   logic [15:0] writeData  = '0;
   logic        memRead    = 1'b0;
   logic        memWrite   = 1'b0;
   logic [15:0] memAddr    = '0;
   logic [15:0] memDataIn  = '0;
   logic [15:0] memDataOut = '0;
   logic        halt       = 1'b0;
   logic [31:0] instCount;
   logic        overflow;
   logic        halted;
   logic        drained;

   commit_trace_if tif ();

   commit_trace #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rst        (rst),
      .regWrite   (regWrite),
      .writeReg   (writeReg),
      .writeData  (writeData),
      .memRead    (memRead),
      .memWrite   (memWrite),
      .memAddr    (memAddr),
      .memDataIn  (memDataIn),
      .memDataOut (memDataOut),
      .halt       (halt),
      .trace      (tif),
      .instCount  (instCount),
      .overflow   (overflow),
      .halted     (halted),
      .drained    (drained)
   );

   // ---------------- scoreboard state ----------------
   int total = 0;
   int bad   = 0;
   logic [65:0] exp_q[$];   // {type, addr, data, cycle}

   // reference model state
   int              m_cnt    = 0;
   bit              m_halted = 1'b0;
   bit              m_ovf    = 1'b0;
   longint unsigned m_inst   = 0;
   int unsigned     m_cyc    = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] ts_now();
      return TS ? 32'(m_cyc) : 32'd0;
   endfunction

   // ---------------- driver tasks ----------------
   // Called just after a falling edge: drives one cycle, predicts, checks status after the edge.
   task automatic step(input logic rw, input logic [2:0] wr, input logic [15:0] wd,
                       input logic mr, input logic mw, input logic [15:0] ma,
                       input logic [15:0] mdi, input logic [15:0] mdo,
                       input logic h, input logic rdy);
      logic [65:0] recs[$];
      int free;
      int pushed;
      int pop;
      regWrite = rw; writeReg = wr; writeData = wd;
      memRead = mr; memWrite = mw; memAddr = ma;
      memDataIn = mdi; memDataOut = mdo; halt = h;
      tif.traceReady = rdy;
      pushed = 0;
      if (!m_halted) begin
         if (rw) recs.push_back({2'd0, {13'd0, wr}, wd, ts_now()});
         if (mw) recs.push_back({2'd2, ma, mdi, ts_now()});
         else if (mr) recs.push_back({2'd1, ma, mdo, ts_now()});
         if (h) recs.push_back({2'd3, 16'd0, 16'd0, ts_now()});
         if ((rw || mw || h) && m_inst < 64'hFFFF_FFFF) m_inst++;
         free = DEPTH - m_cnt;
         if (recs.size() <= free) begin
            foreach (recs[i]) exp_q.push_back(recs[i]);
            pushed = recs.size();
            if (h) m_halted = 1'b1;
         end else begin
            m_ovf = 1'b1;
            if (h && free > 0) begin
               exp_q.push_back(recs[recs.size()-1]);
               pushed = 1;
               m_halted = 1'b1;
            end
         end
      end
      pop = (m_cnt > 0 && rdy) ? 1 : 0;
      @(posedge clk);
      m_cnt = m_cnt - pop + pushed;
      m_cyc++;
      @(negedge clk);
      chk("valid",    64'(tif.traceValid), 64'(m_cnt > 0));
      chk("instcnt",  64'(instCount),      m_inst);
      chk("overflow", 64'(overflow),       64'(m_ovf));
      chk("halted",   64'(halted),         64'(m_halted));
      chk("drained",  64'(drained),        64'(m_halted && m_cnt == 0));
   endtask

   task automatic idle(input logic rdy);
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, rdy);
   endtask

   task automatic store(input logic [15:0] a, input logic [15:0] d, input logic rdy);
      step(1'b0, 3'd0, 16'd0, 1'b0, 1'b1, a, d, 16'd0, 1'b0, rdy);
   endtask

   task automatic rand_step(input int halt_pct, input int ready_pct);
      step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 16'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 99) < 30),
           16'($urandom), 16'($urandom), 16'($urandom),
           ($urandom_range(0, 99) < halt_pct), ($urandom_range(0, 99) < ready_pct));
   endtask

   task automatic drain();
      for (int i = 0; i < 4 * DEPTH; i++) if (m_cnt > 0) idle(1'b1);
   endtask

   // Asserts reset between edges, checks the asynchronous clear, releases on a falling edge.
   task automatic apply_reset();
      #2 rst = 1'b0;
      #1;
      chk("rst_valid",  64'(tif.traceValid), 64'd0);
      chk("rst_type",   64'(tif.traceType),  64'd0);
      chk("rst_addr",   64'(tif.traceAddr),  64'd0);
      chk("rst_data",   64'(tif.traceData),  64'd0);
      chk("rst_cycle",  64'(tif.traceCycle), 64'd0);
      chk("rst_inst",   64'(instCount),      64'd0);
      chk("rst_ovf",    64'(overflow),       64'd0);
      chk("rst_halted", 64'(halted),         64'd0);
      exp_q.delete();
      m_cnt = 0; m_halted = 1'b0; m_ovf = 1'b0; m_inst = 0; m_cyc = 0;
      regWrite = 1'b0; memRead = 1'b0; memWrite = 1'b0; halt = 1'b0;
      tif.traceReady = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // ---------------- monitor ----------------
   initial begin
      logic [65:0] e;
      forever begin
         @(negedge clk);
         #4;
         if (rst && tif.traceValid && tif.traceReady) begin
            if (exp_q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL pop_unexpected actual=type %0d addr %0h required=no record", tif.traceType, tif.traceAddr);
            end else begin
               e = exp_q.pop_front();
               chk("rec_type",  64'(tif.traceType),  64'(e[65:64]));
               chk("rec_addr",  64'(tif.traceAddr),  64'(e[63:48]));
               chk("rec_data",  64'(tif.traceData),  64'(e[47:32]));
               chk("rec_cycle", 64'(tif.traceCycle), 64'(e[31:0]));
            end
         end
      end
   end

   // watchdog
   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      tif.traceReady = 1'b0;
      apply_reset();

      // single register write
      step(1'b1, 3'd3, 16'h1234, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("reg_type", 64'(tif.traceType), 64'd0);
      chk("reg_addr", 64'(tif.traceAddr), 64'h0003);
      chk("reg_data", 64'(tif.traceData), 64'h1234);
      idle(1'b1);
      chk("reg_inst", 64'(instCount), 64'd1);

      // register write plus load in one cycle
      apply_reset();
      step(1'b1, 3'd5, 16'h00AA, 1'b1, 1'b0, 16'h0040, 16'd0, 16'hBEEF, 1'b0, 1'b1);
      chk("pair_first_addr", 64'(tif.traceAddr), 64'h0005);
      idle(1'b1);
      chk("pair_second_type", 64'(tif.traceType), 64'd1);
      chk("pair_second_data", 64'(tif.traceData), 64'hBEEF);
      idle(1'b1);
      chk("pair_inst", 64'(instCount), 64'd1);

      // random traffic, no halts
      repeat (300) rand_step(0, 60);
      drain();

      // timestamps on stores at edges 2 and 7 after release
      apply_reset();
      idle(1'b0); idle(1'b0);
      store(16'h0100, 16'h1111, 1'b0);
      chk("ts_first", 64'(tif.traceCycle), TS ? 64'd2 : 64'd0);
      idle(1'b0); idle(1'b0); idle(1'b0); idle(1'b0);
      store(16'h0104, 16'h2222, 1'b0);
      drain();

      // overflow on the ninth store, then halt with full / one-free FIFO
      apply_reset();
      for (int i = 0; i < 9; i++) store(16'(i * 4), 16'(16'hA000 + i), 1'b0);
      chk("ovf_inst", 64'(instCount), 64'd9);
      chk("ovf_flag", 64'(overflow), 64'd1);
      step(1'b1, 3'd1, 16'h7777, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
      chk("full_halt_not_taken", 64'(halted), 64'd0);
      idle(1'b1);
      step(1'b1, 3'd1, 16'h7777, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b1, 1'b0);
      chk("halt_taken", 64'(halted), 64'd1);
      repeat (12) rand_step(30, 100);
      chk("halt_drained", 64'(drained), 64'd1);
      chk("halt_inst_frozen", 64'(instCount), 64'd11);

      // reset with five records queued
      apply_reset();
      for (int i = 0; i < 5; i++) store(16'(i), 16'(i + 1), 1'b0);
      apply_reset();
      step(1'b1, 3'd2, 16'h55AA, 1'b0, 1'b0, 16'd0, 16'd0, 16'd0, 1'b0, 1'b1);
      chk("post_rst_addr", 64'(tif.traceAddr), 64'h0002);
      idle(1'b1);

      // random traffic with occasional halts
      apply_reset();
      repeat (200) rand_step(2, 50);
      drain();

      chk("exp_q_empty", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
